// File: rtl/out_vc_alloc_pkg.sv
// out_vc_alloc_pkg
// Shared router constants used by the output-VC allocator and its arbiter:
// the default number of output VCs per port, the downstream buffer depth in
// flits, the flit-type encoding and a small width helper.
package out_vc_alloc_pkg;

    localparam int OVA_NUM_OVC    = 4;
    localparam int OVA_CREDIT_MAX = 4;

    typedef enum logic [1:0] {
        FLIT_HEAD     = 2'd0,
        FLIT_BODY     = 2'd1,
        FLIT_TAIL     = 2'd2,
        FLIT_HEADTAIL = 2'd3
    } flit_type_e;

    // Index width that never collapses to zero bits for single-entry sets.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/out_vc_alloc_rr_arbiter.sv
// rr_arbiter
// Combinational round-robin arbiter. The search starts at ptr and moves
// upward, wrapping from N-1 to 0; the first asserted request wins.
// Ports:
//   req   in  N   request vector
//   ptr   in  PW  highest-priority position for this search
//   gnt   out N   one-hot winner (all zero when nothing requests)
//   idx   out PW  winner index
//   valid out 1   at least one request present
module rr_arbiter
    import out_vc_alloc_pkg::*;
#(
    parameter int N  = 20,
    parameter int PW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] idx,
    output logic          valid
);

    int pos;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        pos   = 0;
        for (int k = 0; k < N; k++) begin
            pos = int'(ptr) + k;
            if (pos >= N) pos = pos - N;
            if (!valid && req[pos]) begin
                valid    = 1'b1;
                gnt[pos] = 1'b1;
                idx      = PW'(pos);
            end
        end
    end

endmodule

// File: rtl/out_vc_alloc.sv
// out_vc_alloc
// Output-port VC allocator with per-OVC credit tracking. Each cycle at most
// one waiting input VC is granted the lowest-index free output VC, chosen
// round-robin among requesters. Credits are counted per output VC and
// saturate at 0 / CREDIT_MAX; any protocol violation sets a sticky error.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req           in  NUM_REQ  input VCs waiting for this output port
//   grant         out NUM_REQ  registered one-hot grant (one cycle)
//   grant_vc      out OW       output VC handed out with grant
//   release_valid/release_vc   tail flit freed an output VC
//   dec_valid/dec_vc           flit sent downstream (consumes a credit)
//   inc_valid/inc_vc           credit returned from downstream
//   credit_cnt    out NUM_OVC*CW  per-OVC counts, OVC i at [i*CW +: CW]
//   ovc_busy      out NUM_OVC  output VC currently owned by a packet
//   credit_err    out 1        sticky protocol error
module out_vc_alloc
    import out_vc_alloc_pkg::*;
#(
    parameter int NUM_REQ    = 20,
    parameter int NUM_OVC    = OVA_NUM_OVC,
    parameter int CREDIT_MAX = OVA_CREDIT_MAX,
    parameter int CW         = $clog2(CREDIT_MAX + 1),
    parameter int OW         = idx_width(NUM_OVC)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req,
    output logic [NUM_REQ-1:0]    grant,
    output logic [OW-1:0]         grant_vc,
    input  logic                  release_valid,
    input  logic [OW-1:0]         release_vc,
    input  logic                  dec_valid,
    input  logic [OW-1:0]         dec_vc,
    input  logic                  inc_valid,
    input  logic [OW-1:0]         inc_vc,
    output logic [NUM_OVC*CW-1:0] credit_cnt,
    output logic [NUM_OVC-1:0]    ovc_busy,
    output logic                  credit_err
);

    localparam int PW = idx_width(NUM_REQ);

    logic [PW-1:0]      rr_ptr;
    logic [CW-1:0]      credit_q   [NUM_OVC];
    logic [CW-1:0]      credit_nxt [NUM_OVC];
    logic [NUM_OVC-1:0] busy_nxt;
    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] arb_gnt;
    logic [PW-1:0]      arb_idx;
    logic               arb_valid;
    logic [OW-1:0]      cand;
    logic               any_free;
    logic               alloc;
    logic               rel_err;
    logic               cred_err;
    logic               inc_hit;
    logic               dec_hit;

    // A requester granted last cycle still shows req this cycle; masking it
    // keeps it from being granted a second OVC for the same packet.
    assign eligible = req & ~grant;

    rr_arbiter #(
        .N  (NUM_REQ),
        .PW (PW)
    ) u_arb (
        .req   (eligible),
        .ptr   (rr_ptr),
        .gnt   (arb_gnt),
        .idx   (arb_idx),
        .valid (arb_valid)
    );

    // Lowest-index free OVC; scanning downward lets the lowest index win.
    always_comb begin
        cand     = '0;
        any_free = 1'b0;
        for (int i = NUM_OVC - 1; i >= 0; i--) begin
            if (!ovc_busy[i]) begin
                cand     = OW'(i);
                any_free = 1'b1;
            end
        end
    end

    assign alloc = arb_valid && any_free;

    // The candidate was chosen from pre-release busy, so a freed OVC only
    // becomes allocatable on the following edge.
    always_comb begin
        busy_nxt = ovc_busy;
        rel_err  = 1'b0;
        if (release_valid) begin
            if (int'(release_vc) >= NUM_OVC || !ovc_busy[release_vc]) begin
                rel_err = 1'b1;
            end else begin
                busy_nxt[release_vc] = 1'b0;
            end
        end
        if (alloc) busy_nxt[cand] = 1'b1;
    end

    // Simultaneous inc and dec on one OVC cancel out before any limit check.
    always_comb begin
        credit_nxt = credit_q;
        cred_err   = 1'b0;
        inc_hit    = 1'b0;
        dec_hit    = 1'b0;
        if (inc_valid && int'(inc_vc) >= NUM_OVC) cred_err = 1'b1;
        if (dec_valid && int'(dec_vc) >= NUM_OVC) cred_err = 1'b1;
        for (int i = 0; i < NUM_OVC; i++) begin
            inc_hit = inc_valid && (inc_vc == OW'(i));
            dec_hit = dec_valid && (dec_vc == OW'(i));
            if (inc_hit && !dec_hit) begin
                if (credit_q[i] == CW'(CREDIT_MAX)) cred_err = 1'b1;
                else credit_nxt[i] = credit_q[i] + 1'b1;
            end else if (dec_hit && !inc_hit) begin
                if (credit_q[i] == '0) cred_err = 1'b1;
                else credit_nxt[i] = credit_q[i] - 1'b1;
            end
        end
    end

    always_comb begin
        credit_cnt = '0;
        for (int i = 0; i < NUM_OVC; i++) begin
            credit_cnt[i*CW +: CW] = credit_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grant      <= '0;
            grant_vc   <= '0;
            ovc_busy   <= '0;
            rr_ptr     <= '0;
            credit_err <= 1'b0;
            for (int i = 0; i < NUM_OVC; i++) credit_q[i] <= CW'(CREDIT_MAX);
        end else begin
            grant      <= alloc ? arb_gnt : '0;
            ovc_busy   <= busy_nxt;
            credit_q   <= credit_nxt;
            credit_err <= credit_err | rel_err | cred_err;
            if (alloc) begin
                grant_vc <= cand;
                rr_ptr   <= (int'(arb_idx) == NUM_REQ - 1) ? '0 : arb_idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_out_vc_alloc.sv
// tb_out_vc_alloc
// Directed bench for out_vc_alloc: a table of credit/release vectors with
// hand-computed counts, plus hand-written allocation sequences.
module tb_out_vc_alloc;

    logic        clk = 1'b0;
    logic        rst;
    logic [19:0] req;
    logic [19:0] grant;
    logic [1:0]  grant_vc;
    logic        release_valid;
    logic [1:0]  release_vc;
    logic        dec_valid;
    logic [1:0]  dec_vc;
    logic        inc_valid;
    logic [1:0]  inc_vc;
    logic [11:0] credit_cnt;
    logic [3:0]  ovc_busy;
    logic        credit_err;

    int checks = 0;
    int errors = 0;

    out_vc_alloc dut (
        .clk           (clk),
        .rst           (rst),
        .req           (req),
        .grant         (grant),
        .grant_vc      (grant_vc),
        .release_valid (release_valid),
        .release_vc    (release_vc),
        .dec_valid     (dec_valid),
        .dec_vc        (dec_vc),
        .inc_valid     (inc_valid),
        .inc_vc        (inc_vc),
        .credit_cnt    (credit_cnt),
        .ovc_busy      (ovc_busy),
        .credit_err    (credit_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rst;
        logic        rv;
        logic [1:0]  rvc;
        logic        dv;
        logic [1:0]  dvc;
        logic        iv;
        logic [1:0]  ivc;
        logic [11:0] cnt;
        logic [3:0]  busy;
        logic        err;
    } vec_t;

    vec_t tbl [18];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        rst = 1'b0; req = '0;
        release_valid = 1'b0; release_vc = '0;
        dec_valid = 1'b0; dec_vc = '0;
        inc_valid = 1'b0; inc_vc = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        //            rst  rv   rvc  dv   dvc  iv   ivc  cnt      busy err
        tbl[0]  = '{1'b0,1'b0,2'd0,1'b1,2'd1,1'b0,2'd0,12'h91C,4'h0,1'b0};
        tbl[1]  = '{1'b0,1'b0,2'd0,1'b1,2'd1,1'b0,2'd0,12'h914,4'h0,1'b0};
        tbl[2]  = '{1'b0,1'b0,2'd0,1'b1,2'd1,1'b0,2'd0,12'h90C,4'h0,1'b0};
        tbl[3]  = '{1'b0,1'b0,2'd0,1'b1,2'd1,1'b0,2'd0,12'h904,4'h0,1'b0};
        tbl[4]  = '{1'b0,1'b0,2'd0,1'b1,2'd1,1'b0,2'd0,12'h904,4'h0,1'b1};
        tbl[5]  = '{1'b0,1'b0,2'd0,1'b0,2'd0,1'b1,2'd1,12'h90C,4'h0,1'b1};
        tbl[6]  = '{1'b1,1'b0,2'd0,1'b1,2'd1,1'b0,2'd0,12'h924,4'h0,1'b0};
        tbl[7]  = '{1'b0,1'b0,2'd0,1'b1,2'd3,1'b0,2'd0,12'h724,4'h0,1'b0};
        tbl[8]  = '{1'b0,1'b0,2'd0,1'b1,2'd3,1'b0,2'd0,12'h524,4'h0,1'b0};
        tbl[9]  = '{1'b0,1'b0,2'd0,1'b1,2'd3,1'b1,2'd3,12'h524,4'h0,1'b0};
        tbl[10] = '{1'b0,1'b0,2'd0,1'b0,2'd0,1'b1,2'd3,12'h724,4'h0,1'b0};
        tbl[11] = '{1'b0,1'b0,2'd0,1'b0,2'd0,1'b1,2'd3,12'h924,4'h0,1'b0};
        tbl[12] = '{1'b0,1'b0,2'd0,1'b0,2'd0,1'b1,2'd3,12'h924,4'h0,1'b1};
        tbl[13] = '{1'b1,1'b0,2'd0,1'b0,2'd0,1'b0,2'd0,12'h924,4'h0,1'b0};
        tbl[14] = '{1'b0,1'b0,2'd0,1'b1,2'd0,1'b0,2'd0,12'h923,4'h0,1'b0};
        tbl[15] = '{1'b0,1'b0,2'd0,1'b1,2'd2,1'b1,2'd0,12'h8E4,4'h0,1'b0};
        tbl[16] = '{1'b0,1'b1,2'd1,1'b0,2'd0,1'b0,2'd0,12'h8E4,4'h0,1'b1};
        tbl[17] = '{1'b1,1'b0,2'd0,1'b0,2'd0,1'b0,2'd0,12'h924,4'h0,1'b0};

        // Reset then idle.
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("reset_credit", 32'(credit_cnt), 32'h924);
        chk("reset_busy", 32'(ovc_busy), 32'h0);
        chk("reset_grant", 32'(grant), 32'h0);
        chk("reset_gvc", 32'(grant_vc), 32'h0);
        chk("reset_err", 32'(credit_err), 32'h0);

        // Credit / release vectors.
        for (int i = 0; i < 18; i++) begin
            rst           = tbl[i].rst;
            release_valid = tbl[i].rv;
            release_vc    = tbl[i].rvc;
            dec_valid     = tbl[i].dv;
            dec_vc        = tbl[i].dvc;
            inc_valid     = tbl[i].iv;
            inc_vc        = tbl[i].ivc;
            step();
            chk($sformatf("tbl%0d_cnt", i), 32'(credit_cnt), 32'(tbl[i].cnt));
            chk($sformatf("tbl%0d_busy", i), 32'(ovc_busy), 32'(tbl[i].busy));
            chk($sformatf("tbl%0d_err", i), 32'(credit_err), 32'(tbl[i].err));
            chk($sformatf("tbl%0d_grant", i), 32'(grant), 32'h0);
        end
        idle_inputs();

        // A requester still holding req in its grant cycle is not regranted.
        do_reset();
        req = 20'h00008;
        step();
        chk("mask_g1", 32'(grant), 32'h00008);
        chk("mask_vc1", 32'(grant_vc), 32'd0);
        step();
        chk("mask_g2", 32'(grant), 32'h0);
        chk("mask_busy", 32'(ovc_busy), 32'h1);
        req = '0;

        // req[3] and req[7] together, each dropped after its grant.
        do_reset();
        req = 20'h00088;
        step();
        chk("a_g3", 32'(grant), 32'h00008);
        chk("a_vc0", 32'(grant_vc), 32'd0);
        chk("a_busy1", 32'(ovc_busy), 32'h1);
        req = 20'h00080;
        step();
        chk("a_g7", 32'(grant), 32'h00080);
        chk("a_vc1", 32'(grant_vc), 32'd1);
        chk("a_busy2", 32'(ovc_busy), 32'h3);
        chk("a_rrptr", 32'(dut.rr_ptr), 32'd8);
        req = '0;
        step();
        chk("a_idle_grant", 32'(grant), 32'h0);
        chk("a_vc_hold", 32'(grant_vc), 32'd1);

        // Fill all OVCs, then release OVC 2 with req[5] waiting.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            req = 20'(1) << k;
            step();
            chk($sformatf("b_fill_g%0d", k), 32'(grant), 32'(1) << k);
            chk($sformatf("b_fill_vc%0d", k), 32'(grant_vc), 32'(k));
        end
        req = 20'h00020;
        step();
        chk("b_full_grant", 32'(grant), 32'h0);
        chk("b_full_busy", 32'(ovc_busy), 32'hF);
        release_valid = 1'b1;
        release_vc    = 2'd2;
        step();
        chk("b_rel_grant", 32'(grant), 32'h0);
        chk("b_rel_busy", 32'(ovc_busy), 32'hB);
        release_valid = 1'b0;
        step();
        chk("b_g5", 32'(grant), 32'h00020);
        chk("b_vc2", 32'(grant_vc), 32'd2);
        chk("b_busy", 32'(ovc_busy), 32'hF);
        chk("b_err", 32'(credit_err), 32'h0);
        req = '0;
        step();
        chk("b_drop", 32'(grant), 32'h0);

        // All requesters held; each granted OVC released the next cycle.
        do_reset();
        req = 20'hFFFFF;
        for (int k = 0; k < 21; k++) begin
            step();
            chk($sformatf("c_grant%0d", k), 32'(grant), 32'(1) << (k % 20));
            chk($sformatf("c_vc%0d", k), 32'(grant_vc), 32'(k % 2));
            release_valid = 1'b1;
            release_vc    = 2'(k % 2);
        end
        release_valid = 1'b0;
        chk("c_err", 32'(credit_err), 32'h0);

        // Reset mid-operation overrides all same-cycle activity.
        rst           = 1'b1;
        release_valid = 1'b1;
        release_vc    = 2'd0;
        dec_valid     = 1'b1;
        dec_vc        = 2'd1;
        inc_valid     = 1'b1;
        inc_vc        = 2'd2;
        step();
        chk("r_grant", 32'(grant), 32'h0);
        chk("r_gvc", 32'(grant_vc), 32'h0);
        chk("r_busy", 32'(ovc_busy), 32'h0);
        chk("r_cnt", 32'(credit_cnt), 32'h924);
        chk("r_err", 32'(credit_err), 32'h0);
        chk("r_rrptr", 32'(dut.rr_ptr), 32'd0);
        idle_inputs();
        step();
        chk("r_after", 32'(grant), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
